// File: rtl/i2c_slave_regs.sv
// -----------------------------------------------------------------------------
// i2c_slave_regs
//   I2C target with a 16 x 8-bit register bank. An initiator writes a pointer
//   byte and then data bytes, or reads bytes back starting at the pointer. The
//   pointer auto-increments and wraps from 15 to 0. SCL/SDA are oversampled on
//   PCLK, which must run at 16x SCL or faster.
//
// Ports
//   PCLK        system clock (rising edge)
//   PRESETn     asynchronous active-low reset
//   SCL         I2C clock from the initiator (asynchronous to PCLK)
//   SDA         I2C data, open-drain: driven 0 while SDA_ENABLE=1, else high-Z
//   SDA_ENABLE  high while this block pulls SDA low
//   LOC_ADDR    local read index into the register bank
//   LOC_RDATA   combinational reg[LOC_ADDR]
//   WR_STROBE   one-PCLK pulse when a bank register is written over I2C
//   WR_ADDR     index written, valid with WR_STROBE
//   WR_DATA     byte written, valid with WR_STROBE
//   BUSY        high from an address-matched START until STOP
// -----------------------------------------------------------------------------
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       SCL,
  inout  wire        SDA,
  output logic       SDA_ENABLE,
  input  logic [3:0] LOC_ADDR,
  output logic [7:0] LOC_RDATA,
  output logic       WR_STROBE,
  output logic [3:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  output logic       BUSY
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK,
    RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  state_t     state;
  logic [7:0] regs [16];
  logic [3:0] ptr;
  logic [7:0] shift;
  logic [3:0] bit_cnt;
  logic       rw;

  logic scl_meta, scl_sync, scl_prev;
  logic sda_meta, sda_sync, sda_prev;

  // Open-drain output: only ever pull low, the bus pull-up supplies the 1.
  assign SDA       = SDA_ENABLE ? 1'b0 : 1'bz;
  assign LOC_RDATA = regs[LOC_ADDR];

  // Two-flop synchronizers plus one history flop for edge detection. They
  // reset to 1 (idle bus level) so leaving reset never looks like a START.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, exactly like the hardware it becomes.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      scl_prev <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_meta <= SCL;
      scl_sync <= scl_meta;
      scl_prev <= scl_sync;
      sda_meta <= SDA;
      sda_sync <= sda_meta;
      sda_prev <= sda_sync;
    end
  end

  logic       start_det, stop_det, scl_rise, scl_fall, last_bit;
  logic [7:0] byte_in;

  assign start_det = scl_sync &  sda_prev & ~sda_sync;
  assign stop_det  = scl_sync & ~sda_prev &  sda_sync;
  assign scl_rise  = ~scl_prev &  scl_sync;
  assign scl_fall  =  scl_prev & ~scl_sync;
  assign byte_in   = {shift[6:0], sda_sync};
  assign last_bit  = (bit_cnt == 4'd7);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= IDLE;
      // NOTE: the bank is reset element by element because it must read back
      // as 00 after reset; this makes it flops rather than a RAM macro.
      for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
      ptr        <= 4'd0;
      shift      <= 8'h00;
      bit_cnt    <= 4'd0;
      rw         <= 1'b0;
      SDA_ENABLE <= 1'b0;
      BUSY       <= 1'b0;
      WR_STROBE  <= 1'b0;
      WR_ADDR    <= 4'd0;
      WR_DATA    <= 8'h00;
    end else begin
      WR_STROBE <= 1'b0;
      if (stop_det) begin
        // Any partial byte in shift is simply dropped.
        state      <= IDLE;
        SDA_ENABLE <= 1'b0;
        BUSY       <= 1'b0;
        bit_cnt    <= 4'd0;
        shift      <= 8'h00;
      end else if (start_det) begin
        // Pointer is kept so a repeated START can turn a pointer write into a read.
        state      <= ADDR;
        SDA_ENABLE <= 1'b0;
        bit_cnt    <= 4'd0;
        shift      <= 8'h00;
      end else begin
        unique case (state)
          ADDR: if (scl_rise) begin
            shift <= byte_in;
            if (last_bit) begin
              bit_cnt <= 4'd0;
              if (byte_in[7:1] == SLAVE_ADDR) begin
                rw    <= byte_in[0];
                BUSY  <= 1'b1;
                state <= ADDR_ACK;
              end else begin
                state <= WAIT_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end

          // ACK phases: SDA_ENABLE doubles as the phase flag. The first falling
          // edge after bit 8 pulls low, the falling edge after bit 9 releases.
          ADDR_ACK: if (scl_fall) begin
            if (!SDA_ENABLE) begin
              SDA_ENABLE <= 1'b1;
            end else if (rw) begin
              // Present the MSB of the first read byte on this same edge.
              shift      <= regs[ptr];
              SDA_ENABLE <= ~regs[ptr][7];
              state      <= RDATA;
            end else begin
              SDA_ENABLE <= 1'b0;
              state      <= PTR;
            end
          end

          PTR: if (scl_rise) begin
            shift <= byte_in;
            if (last_bit) begin
              ptr     <= byte_in[3:0];
              bit_cnt <= 4'd0;
              state   <= PTR_ACK;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end

          PTR_ACK, WDATA_ACK: if (scl_fall) begin
            if (!SDA_ENABLE) begin
              SDA_ENABLE <= 1'b1;
            end else begin
              SDA_ENABLE <= 1'b0;
              state      <= WDATA;
            end
          end

          WDATA: if (scl_rise) begin
            shift <= byte_in;
            if (last_bit) begin
              regs[ptr] <= byte_in;
              WR_STROBE <= 1'b1;
              WR_ADDR   <= ptr;
              WR_DATA   <= byte_in;
              ptr       <= ptr + 4'd1;
              bit_cnt   <= 4'd0;
              state     <= WDATA_ACK;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end

          // shift[7] always holds the bit to present on the next falling edge.
          RDATA: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                SDA_ENABLE <= 1'b0;
                ptr        <= ptr + 4'd1;
                bit_cnt    <= 4'd0;
                state      <= RDATA_ACK;
              end else begin
                SDA_ENABLE <= ~shift[7];
              end
            end
          end

          RDATA_ACK: if (scl_rise) begin
            if (!sda_sync) begin
              shift <= regs[ptr];
              state <= RDATA;
            end else begin
              state <= WAIT_STOP;
            end
          end

          default: ;  // IDLE, WAIT_STOP: only START/STOP matter
        endcase
      end
    end
  end

endmodule
